// File: rtl/clock_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_counter_pkg
// Description : Shared constants for the clock counter CSR front-end:
//               command codes, register address map, STATUS bit positions
//               and command sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_counter_pkg;

  // Counter command codes (any code above CMD_SNAP is illegal)
  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_SNAP  = 2'd3;

  // Word address map
  localparam logic [1:0] ADDR_CMD      = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_SNAPSHOT = 2'd2;
  localparam logic [1:0] ADDR_LIVE     = 2'd3;

  // STATUS register bit positions
  localparam int STATUS_RUN_BIT  = 0;
  localparam int STATUS_OVF_BIT  = 1;
  localparam int STATUS_ERR_BIT  = 2;
  localparam int STATUS_BUSY_BIT = 3;

  // Command sequencer state encoding
  localparam int         STATE_W   = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // Settle counter width; covers SETTLE_CYCLES up to 15
  localparam int SETTLE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/cc_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cc_cmd_fsm
// Description : IDLE/ISSUE/SETTLE command sequencer. A go pulse in IDLE
//               produces a single ISSUE cycle followed by SETTLE_CYCLES of
//               SETTLE, stalling the bus throughout.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_cmd_fsm
  import clock_counter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_go,
  output logic o_issue,
  output logic o_waitrequest,
  output logic o_busy
);

  localparam logic [SETTLE_CNT_W-1:0] c_SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  logic [STATE_W-1:0]      r_state;
  logic [STATE_W-1:0]      w_next_state;
  logic [SETTLE_CNT_W-1:0] r_settle;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Settle counter: zeroed during ISSUE, counts SETTLE cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_settle <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_go) w_next_state = ST_ISSUE;
      ST_ISSUE:  w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_settle == c_SETTLE_LAST) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: strobe only in ISSUE, stall in both non-idle states
  always_comb begin
    o_issue       = 1'b0;
    o_waitrequest = 1'b0;
    o_busy        = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        o_issue       = 1'b1;
        o_waitrequest = 1'b1;
        o_busy        = 1'b1;
      end
      ST_SETTLE: begin
        o_waitrequest = 1'b1;
        o_busy        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/clock_counter_csr.sv
`default_nettype none
// ============================================================================
// Module      : clock_counter_csr
// Description : Avalon-MM style control/status front-end for the clock
//               counter: command strobes, running state, snapshot register,
//               sticky overflow and illegal-command error.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_counter_csr
  import clock_counter_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_write,
  input  logic [CNT_W-1:0] avs_writedata,
  input  logic             avs_read,
  output logic [CNT_W-1:0] avs_readdata,
  output logic             avs_readdatavalid,
  output logic             avs_waitrequest,
  output logic             cnt_enable,
  output logic [CNT_W-1:0] cnt_command,
  input  logic [CNT_W-1:0] cnt_count,
  output logic             busy
);

  logic             w_issue;
  logic             w_wait;
  logic             w_busy;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_cmd_legal;
  logic             w_cmd_go;
  logic             w_cmd_bad;
  logic [CNT_W-1:0] w_status;
  logic [CNT_W-1:0] w_rd_mux;

  logic [CNT_W-1:0] r_cmd;
  logic             r_running;
  logic             r_ovf;
  logic             r_err;
  logic [CNT_W-1:0] r_snapshot;
  logic [CNT_W-1:0] r_prev_count;
  logic [CNT_W-1:0] r_readdata;
  logic             r_readdatavalid;

  cc_cmd_fsm #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_cmd_fsm (
    .clk           (clk),
    .reset         (reset),
    .i_go          (w_cmd_go),
    .o_issue       (w_issue),
    .o_waitrequest (w_wait),
    .o_busy        (w_busy)
  );

  // A write wins over a simultaneous read; the read is simply dropped
  assign w_wr_acc    = avs_write & ~w_wait;
  assign w_rd_acc    = avs_read & ~avs_write & ~w_wait;
  assign w_cmd_legal = (avs_writedata[CNT_W-1:2] == '0);
  assign w_cmd_go    = w_wr_acc & (avs_address == ADDR_CMD) & w_cmd_legal;
  assign w_cmd_bad   = w_wr_acc & (avs_address == ADDR_CMD) & ~w_cmd_legal;

  // Latch the command code on acceptance; it holds after the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd <= '0;
    end else if (w_cmd_go) begin
      r_cmd <= avs_writedata;
    end
  end

  // Running/overflow/error/snapshot state; CLEAR in ISSUE overrides overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_running    <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_snapshot   <= '0;
      r_prev_count <= '0;
    end else begin
      r_prev_count <= cnt_count;
      if (r_running && (cnt_count < r_prev_count)) begin
        r_ovf <= 1'b1;
      end
      if (w_cmd_bad) begin
        r_err <= 1'b1;
      end
      if (w_issue) begin
        case (r_cmd[1:0])
          CMD_CLEAR: begin
            r_running  <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_snapshot <= '0;
          end
          CMD_START: r_running <= 1'b1;
          CMD_STOP: begin
            r_running  <= 1'b0;
            r_snapshot <= cnt_count;
          end
          CMD_SNAP:  r_snapshot <= cnt_count;
          default: ;
        endcase
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status                  = '0;
    w_status[STATUS_RUN_BIT]  = r_running;
    w_status[STATUS_OVF_BIT]  = r_ovf;
    w_status[STATUS_ERR_BIT]  = r_err;
    w_status[STATUS_BUSY_BIT] = w_busy;
  end

  // Read mux; the CMD register is write-only and reads as zero
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_STATUS:   w_rd_mux = w_status;
      ADDR_SNAPSHOT: w_rd_mux = r_snapshot;
      ADDR_LIVE:     w_rd_mux = cnt_count;
      default:       w_rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read latency; data bus is zero outside the valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdatavalid <= 1'b0;
      r_readdata      <= '0;
    end else begin
      r_readdatavalid <= w_rd_acc;
      r_readdata      <= w_rd_acc ? w_rd_mux : '0;
    end
  end

  assign avs_readdata      = r_readdata;
  assign avs_readdatavalid = r_readdatavalid;
  assign avs_waitrequest   = w_wait;
  assign cnt_enable        = w_issue;
  assign cnt_command       = r_cmd;
  assign busy              = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_clock_counter_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_counter_csr
// Description : Self-checking bench for clock_counter_csr: directed scenarios
//               plus randomized bus traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_counter_csr;

  localparam int         CNT_W  = 32;
  localparam int         SETTLE = 2;
  localparam logic [1:0] A_CMD  = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_SNAP = 2'd2;
  localparam logic [1:0] A_LIVE = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       avs_address;
  logic             avs_write;
  logic [CNT_W-1:0] avs_writedata;
  logic             avs_read;
  logic [CNT_W-1:0] avs_readdata;
  logic             avs_readdatavalid;
  logic             avs_waitrequest;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_command;
  logic [CNT_W-1:0] cnt_count;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  // Strobe monitor
  int          strobe_cnt = 0;
  logic [31:0] strobe_q[$];

  // Reference model state
  bit          m_running, m_ovf, m_err;
  logic [31:0] m_snap, m_count;

  clock_counter_csr #(
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .cnt_enable        (cnt_enable),
    .cnt_command       (cnt_command),
    .cnt_count         (cnt_count),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_enable) begin
      strobe_cnt++;
      strobe_q.push_back(cnt_command);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", n_err);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  task automatic model_reset();
    m_running = 0; m_ovf = 0; m_err = 0; m_snap = '0;
  endtask

  task automatic model_cmd(input logic [31:0] code);
    if (code > 32'd3)       m_err = 1;
    else if (code == 32'd0) begin m_running = 0; m_ovf = 0; m_err = 0; m_snap = '0; end
    else if (code == 32'd1) m_running = 1;
    else if (code == 32'd2) begin m_running = 0; m_snap = m_count; end
    else                    m_snap = m_count;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      A_STAT:  return {29'd0, m_err, m_ovf, m_running};
      A_SNAP:  return m_snap;
      A_LIVE:  return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---- bus tasks (called and returning at a falling edge) ------------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit rd, output int stalls);
    int n = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = rd;
    while (avs_waitrequest && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_eq("wr_timeout", 32'(n), 32'd0);
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
    stalls = n;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    int n = 0;
    avs_address = a; avs_read = 1'b1;
    while (avs_waitrequest && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_eq("rd_timeout", 32'(n), 32'd0);
    @(negedge clk);
    avs_read = 1'b0;
    check_eq("rd_valid", 32'(avs_readdatavalid), 32'd1);
    d = avs_readdata;
    @(negedge clk);
    check_eq("rd_idle_data", {avs_readdata[30:0], avs_readdatavalid}, 32'd0);
  endtask

  // Observe the command window starting at the cycle after acceptance
  task automatic watch_cmd(input bit legal, input logic [31:0] code);
    int          en = 0;
    int          wr = 0;
    logic [31:0] seen = '0;
    for (int i = 0; i < 8; i++) begin
      if (cnt_enable) begin en++; seen = cnt_command; end
      if (avs_waitrequest) wr++;
      @(negedge clk);
    end
    check_eq("strobe_count", 32'(en), legal ? 32'd1 : 32'd0);
    check_eq("wait_cycles", 32'(wr), legal ? 32'(1 + SETTLE) : 32'd0);
    if (legal) check_eq("strobe_code", seen, code);
  endtask

  task automatic do_cmd(input logic [31:0] code, input bit rd);
    int st;
    bus_write(A_CMD, code, rd, st);
    check_eq("wr_no_stall", 32'(st), 32'd0);
    if (rd) check_eq("rw_no_rdv", 32'(avs_readdatavalid), 32'd0);
    watch_cmd(code < 32'd4, code);
    model_cmd(code);
  endtask

  task automatic read_check(input string tag, input logic [1:0] a);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, model_read(a));
  endtask

  task automatic set_count(input logic [31:0] v);
    cnt_count = v;
    if (m_running && (v < m_count)) m_ovf = 1;
    m_count = v;
    @(negedge clk);
  endtask

  // ---- stimulus -------------------------------------------------------------
  initial begin
    logic [31:0] d;
    int          s0, st;
    int          op;
    logic [31:0] code;

    reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; cnt_count = '0;
    m_count = '0; model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_enable", 32'(cnt_enable), 32'd0);
    check_eq("rst_wait", 32'(avs_waitrequest), 32'd0);
    check_eq("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    check_eq("rst_rdata", avs_readdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd", cnt_command, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read STATUS after reset; no strobe ever seen
    bus_read(A_STAT, d);
    check_eq("t1_status", d, 32'd0);
    check_eq("t1_no_strobe", 32'(strobe_cnt), 32'd0);

    // START
    do_cmd(32'd1, 1'b0);
    read_check("t2_status", A_STAT);

    // STOP snapshots the count
    set_count(32'h0000_1234);
    do_cmd(32'd2, 1'b0);
    bus_read(A_SNAP, d);
    check_eq("t3_snapshot", d, 32'h0000_1234);
    bus_read(A_STAT, d);
    check_eq("t3_status", d, 32'd0);

    // Overflow while running, then CLEAR
    do_cmd(32'd1, 1'b0);
    set_count(32'hFFFF_FFFF);
    set_count(32'h0000_0000);
    bus_read(A_STAT, d);
    check_eq("t4_ovf_bit", 32'(d[1]), 32'd1);
    check_eq("t4_status", d, model_read(A_STAT));
    do_cmd(32'd0, 1'b0);
    bus_read(A_STAT, d);
    check_eq("t4_clear_status", d, 32'd0);

    // Illegal command, then back-to-back writes
    do_cmd(32'd7, 1'b0);
    bus_read(A_STAT, d);
    check_eq("t5_err_status", d, 32'h4);
    s0 = strobe_cnt;
    bus_write(A_CMD, 32'd1, 1'b0, st);
    bus_write(A_CMD, 32'd3, 1'b0, st);
    check_eq("t5_b2b_stalls", 32'(st), 32'(1 + SETTLE));
    repeat (8) @(negedge clk);
    check_eq("t5_b2b_strobes", 32'(strobe_cnt - s0), 32'd2);
    if (strobe_q.size() >= 2) begin
      check_eq("t5_b2b_first", strobe_q[strobe_q.size()-2], 32'd1);
      check_eq("t5_b2b_second", strobe_q[strobe_q.size()-1], 32'd3);
    end else begin
      check_eq("t5_b2b_queue", 32'(strobe_q.size()), 32'd2);
    end
    model_cmd(32'd1);
    model_cmd(32'd3);
    read_check("t5_status", A_STAT);
    read_check("t5_snapshot", A_SNAP);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1: begin
          code = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(4, 300));
          do_cmd(code, op == 1);
          read_check("rnd_status_after_cmd", A_STAT);
        end
        2: begin
          bus_write(2'($urandom_range(1, 3)), $urandom(), 1'b0, st);
          watch_cmd(1'b0, 32'd0);
        end
        3: read_check("rnd_read", 2'($urandom_range(0, 3)));
        4: begin
          if ($urandom_range(0, 1) == 0) set_count($urandom());
          else set_count(m_count + 32'($urandom_range(0, 16)) - 32'd8);
        end
        default: read_check("rnd_status", A_STAT);
      endcase
    end

    // Reset during SETTLE abandons the command and clears state
    set_count(32'h0000_0055);
    do_cmd(32'd3, 1'b0);
    do_cmd(32'd7, 1'b0);
    bus_write(A_CMD, 32'd1, 1'b0, st);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_wait", 32'(avs_waitrequest), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_enable", 32'(cnt_enable), 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    bus_read(A_SNAP, d);
    check_eq("t6_snapshot", d, 32'd0);
    bus_read(A_STAT, d);
    check_eq("t6_status", d, 32'd0);

    // Reset during ISSUE: START must not take effect
    bus_write(A_CMD, 32'd1, 1'b0, st);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6b_wait", 32'(avs_waitrequest), 32'd0);
    bus_read(A_STAT, d);
    check_eq("t6b_status", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
